// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose:
//   Parametrised VGA timing generator and two-stage pixel pipeline. A clock
//   divider produces a one-CLK pixel strobe; horizontal/vertical counters run
//   on that strobe and produce sync pulses and a display-enable window. Stage 1
//   registers the scaled frame-buffer address together with de/hs/vs; stage 2,
//   one pixel period later, maps the returned RAM data through the palette and
//   drives the sync outputs, keeping colour and sync aligned.
//
// Ports:
//   CLK            in   system clock
//   RESETN         in   synchronous active-low reset
//   ENABLE         in   high = run, low = synchronous restart and blank
//   CONFIG_COLOURS in   palette, entry i = bits [8i+7:8i]
//   PIX_EN         out  pixel strobe, one CLK wide (also the RAM clock enable)
//   VGA_ADDR       out  frame-buffer read address {y_tex, x_tex}
//   VGA_DATA       in   RAM read data for VGA_ADDR, sampled on PIX_EN
//   VGA_HS/VGA_VS  out  sync outputs, active level HS_POL/VS_POL
//   VGA_COLOUR     out  pixel colour {R[2:0],G[2:0],B[1:0]}
//   FRAME_START    out  one-CLK pulse after output pixel (h,v)=(0,0) is shown
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int   CLK_DIV    = 4,
  parameter int   H_DISP     = 640,
  parameter int   H_FP       = 16,
  parameter int   H_PW       = 96,
  parameter int   H_BP       = 48,
  parameter int   V_DISP     = 480,
  parameter int   V_FP       = 10,
  parameter int   V_PW       = 2,
  parameter int   V_BP       = 33,
  parameter logic HS_POL     = 1'b0,
  parameter logic VS_POL     = 1'b0,
  parameter int   SCALE_LOG2 = 2,
  parameter int   PIX_BITS   = 1,
  parameter int   X_W        = $clog2(H_DISP >> SCALE_LOG2),
  parameter int   Y_W        = $clog2(V_DISP >> SCALE_LOG2)
) (
  input  logic                        CLK,
  input  logic                        RESETN,
  input  logic                        ENABLE,
  input  logic [8*(2**PIX_BITS)-1:0]  CONFIG_COLOURS,
  output logic                        PIX_EN,
  output logic [Y_W+X_W-1:0]          VGA_ADDR,
  input  logic [PIX_BITS-1:0]         VGA_DATA,
  output logic                        VGA_HS,
  output logic                        VGA_VS,
  output logic [7:0]                  VGA_COLOUR,
  output logic                        FRAME_START
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int H_TOT = H_PW + H_BP + H_DISP + H_FP;
  localparam int V_TOT = V_PW + V_BP + V_DISP + V_FP;

  // One extra bit of headroom so the visible-window end (which may equal the
  // total when the front porch is zero) is always representable.
  localparam int H_CW  = $clog2(H_TOT + 1);
  localparam int V_CW  = $clog2(V_TOT + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PAL_N = 2 ** PIX_BITS;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);

  localparam logic [H_CW-1:0]  H_LAST    = H_CW'(H_TOT - 1);
  localparam logic [H_CW-1:0]  H_SYNC_E  = H_CW'(H_PW);
  localparam logic [H_CW-1:0]  H_VIS_B   = H_CW'(H_PW + H_BP);
  localparam logic [H_CW-1:0]  H_VIS_E   = H_CW'(H_PW + H_BP + H_DISP);

  localparam logic [V_CW-1:0]  V_LAST    = V_CW'(V_TOT - 1);
  localparam logic [V_CW-1:0]  V_SYNC_E  = V_CW'(V_PW);
  localparam logic [V_CW-1:0]  V_VIS_B   = V_CW'(V_PW + V_BP);
  localparam logic [V_CW-1:0]  V_VIS_E   = V_CW'(V_PW + V_BP + V_DISP);

  // ENABLE low behaves exactly like reset, so both collapse into one run flag.
  logic run;
  assign run = RESETN && ENABLE;

  // ---------------------------------------------------------------------------
  // Palette unpacking
  // ---------------------------------------------------------------------------
  logic [7:0] palette [PAL_N];

  genvar gi;
  generate
    for (gi = 0; gi < PAL_N; gi++) begin : g_palette
      assign palette[gi] = CONFIG_COLOURS[8*gi +: 8];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Pixel strobe
  // The strobe is registered from the divider terminal count, so it is low
  // during reset and, for CLK_DIV = 1, high on every cycle once running.
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_reg;
  logic             pix_en_reg;

  always_ff @(posedge CLK) begin
    if (!run) begin
      div_reg    <= '0;
      pix_en_reg <= 1'b0;
    end else begin
      div_reg    <= (div_reg == DIV_LAST) ? '0 : div_reg + DIV_W'(1);
      pix_en_reg <= (div_reg == DIV_LAST);
    end
  end

  // ---------------------------------------------------------------------------
  // Horizontal / vertical counters
  // ---------------------------------------------------------------------------
  logic [H_CW-1:0] h_reg;
  logic [V_CW-1:0] v_reg;

  always_ff @(posedge CLK) begin
    if (!run) begin
      h_reg <= '0;
      v_reg <= '0;
    end else if (pix_en_reg) begin
      if (h_reg == H_LAST) begin
        h_reg <= '0;
        v_reg <= (v_reg == V_LAST) ? '0 : v_reg + V_CW'(1);
      end else begin
        h_reg <= h_reg + H_CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Counter decode: sync, display window, texel coordinates
  // ---------------------------------------------------------------------------
  logic            h_vis;
  logic            v_vis;
  logic            de;
  logic            hs_act;
  logic            vs_act;
  logic            first_pix;
  logic [H_CW-1:0] x_off;
  logic [V_CW-1:0] y_off;
  logic [X_W-1:0]  x_tex;
  logic [Y_W-1:0]  y_tex;
  logic [Y_W+X_W-1:0] addr_next;

  assign h_vis     = (h_reg >= H_VIS_B) && (h_reg < H_VIS_E);
  assign v_vis     = (v_reg >= V_VIS_B) && (v_reg < V_VIS_E);
  assign de        = h_vis && v_vis;
  assign hs_act    = (h_reg < H_SYNC_E);
  assign vs_act    = (v_reg < V_SYNC_E);
  assign first_pix = (h_reg == '0) && (v_reg == '0);

  // Offsets are only meaningful inside the window; outside it the address is
  // forced to zero, so the wrapped subtraction never reaches the RAM.
  assign x_off     = h_reg - H_VIS_B;
  assign y_off     = v_reg - V_VIS_B;
  assign x_tex     = X_W'(x_off >> SCALE_LOG2);
  assign y_tex     = Y_W'(y_off >> SCALE_LOG2);
  assign addr_next = de ? {y_tex, x_tex} : '0;

  // ---------------------------------------------------------------------------
  // Stage 1: address to RAM, timing flags alongside it
  // ---------------------------------------------------------------------------
  logic [Y_W+X_W-1:0] addr_reg;
  logic               s1_de_reg;
  logic               s1_hs_reg;
  logic               s1_vs_reg;
  logic               s1_first_reg;

  always_ff @(posedge CLK) begin
    if (!run) begin
      addr_reg     <= '0;
      s1_de_reg    <= 1'b0;
      s1_hs_reg    <= 1'b0;
      s1_vs_reg    <= 1'b0;
      s1_first_reg <= 1'b0;
    end else if (pix_en_reg) begin
      addr_reg     <= addr_next;
      s1_de_reg    <= de;
      s1_hs_reg    <= hs_act;
      s1_vs_reg    <= vs_act;
      s1_first_reg <= first_pix;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: palette lookup and sync outputs
  // The RAM has had a full pixel period to answer, so VGA_DATA is taken
  // directly on the strobe. The palette is read live at this edge, which is
  // why palette writes land on the next stage-2 update.
  // ---------------------------------------------------------------------------
  logic [7:0] colour_reg;
  logic       hs_reg;
  logic       vs_reg;
  logic       frame_start_reg;

  always_ff @(posedge CLK) begin
    if (!run) begin
      colour_reg      <= 8'h00;
      hs_reg          <= ~HS_POL;
      vs_reg          <= ~VS_POL;
      frame_start_reg <= 1'b0;
    end else begin
      // Set on the same edge as the stage-2 update for (0,0); cleared on the
      // next edge because either the strobe is low or the flag has moved on.
      frame_start_reg <= pix_en_reg && s1_first_reg;
      if (pix_en_reg) begin
        colour_reg <= s1_de_reg ? palette[VGA_DATA] : 8'h00;
        hs_reg     <= s1_hs_reg ? HS_POL : ~HS_POL;
        vs_reg     <= s1_vs_reg ? VS_POL : ~VS_POL;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign PIX_EN      = pix_en_reg;
  assign VGA_ADDR    = addr_reg;
  assign VGA_HS      = hs_reg;
  assign VGA_VS      = vs_reg;
  assign VGA_COLOUR  = colour_reg;
  assign FRAME_START = frame_start_reg;

endmodule
